pe_pad_sched: RTL and testbench
===============================

Name: pe_pad_sched

Overview:
Loop-nest scheduler for one PE's scratchpads. On start it latches the tile configuration and walks the nest Tw > R > Pch > Pm, issuing one MAC step per cycle. Each step carries an IPad, WPad and PPad read address plus first/last-pixel flags to the datapath. It also issues the PPad write-back, delayed by the datapath latency. It sits between the PE instruction/config registers and the PE datapath.

Parameters:
IPadSize, 12, IPad depth; IPad addresses wrap modulo this value
WPadSize, 48, WPad depth
PPadSize, 64, PPad depth
IAW, $clog2(IPadSize), IPad address width
WAW, $clog2(WPadSize), WPad address width
PAW, $clog2(PPadSize), PPad address width
LAT, 2, cycles from rd_vld to the matching psum write (1..7)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst_start  in  1  start pulse; samples the conf_* inputs
inst_stall  in  1  freeze scheduler and write pipeline
inst_reset  in  1  soft abort; same effect as rst on this block
conf_pch  in  4  channels per pass
conf_pm  in  5  filters per pass
conf_r  in  4  filter width
conf_tw  in  7  output pixels in tile
conf_upix  in  6  IPad base advance per output pixel (U*Pch)
ipad_raddr  out  IAW  IPad read address
wpad_raddr  out  WAW  WPad read address
ppad_raddr  out  PAW  PPad read address
rd_vld  out  1  read addresses valid this cycle
fstpix  out  1  step has r==0 and c==0; datapath initialises psum to 0
lstpix  out  1  step has r==R-1 and c==Pch-1
ppad_waddr  out  PAW  PPad write address
ppad_wen  out  1  PPad write enable
busy  out  1  block is active
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst or inst_reset): state IDLE; all outputs 0; counters and write pipeline cleared. inst_reset takes priority over inst_start in the same cycle. Reset mid-run aborts the run: no further rd_vld or ppad_wen, no done pulse.
- States:
  - IDLE: inst_start=1 latches conf_*, goes to RUN.
  - RUN: emits steps. After the last step it goes to DRAIN.
  - DRAIN: waits until the write pipeline is empty, then goes to DONE.
  - DONE: asserts done for one cycle, then returns to IDLE.
  - inst_start outside IDLE is ignored.
- Zero configuration: if any of pch, pm, r or tw is 0, IDLE goes to DONE. done is asserted 1 cycle after start; no reads, no writes.
- Counters: m (innermost), c, r, tw. m wraps at Pm and carries into c; c wraps at Pch and carries into r; r wraps at R and carries into tw. The step with tw==Tw-1, r==R-1, c==Pch-1, m==Pm-1 is the last step.
- Addresses are registered outputs. The step for counter state k appears on the outputs in the cycle after the counter holds k. The first rd_vld is in the cycle after inst_start.
  - wpad_raddr: 0 at the start of each tw; +1 per step.
  - ipad_raddr: ibase + (r*Pch + c), modulo IPadSize. ibase starts at 0 and gains conf_upix (modulo IPadSize) on each tw advance. Built with incremental counters; no multipliers.
  - ppad_raddr: pbase + m. pbase starts at 0 and gains Pm on each tw advance. No wrap; configs with Tw*Pm > PPadSize are illegal and the result is undefined.
  - Configs with Pch*Pm*R > WPadSize are illegal and the result is undefined.
- Write pipeline: LAT-deep shift of {rd_vld, ppad_raddr}. ppad_wen and ppad_waddr equal rd_vld and ppad_raddr from LAT un-stalled cycles earlier.
- busy: high from the cycle after start through the done cycle, inclusive.
- done: 1 cycle after the last ppad_wen.
- Stall: inst_stall=1 holds the counters, address registers and write pipeline. rd_vld=0 and ppad_wen=0 during the stall. The sequence resumes unchanged after the stall; busy stays high. A stall in IDLE has no effect. Stall in DONE does not delay the done pulse.

Test Plan:
- Basic nest: pch=2, pm=3, r=2, tw=2, upix=2, LAT=2, start at cycle 0 -> rd_vld in cycles 1..24.
  - tw0: wpad 0..11; ipad 0,0,0,1,1,1,2,2,2,3,3,3; ppad 0,1,2 repeated; fstpix in cycles 1-3; lstpix in cycles 10-12.
  - tw1: wpad 0..11; ipad 2,2,2 ... 5,5,5; ppad 3,4,5.
  - ppad_wen in cycles 3..26 with waddr equal to raddr from 2 cycles earlier; done in cycle 27; busy in cycles 1..27.
- IPad wrap: pch=1, pm=1, r=4, tw=3, upix=5 -> ipad sequence 0,1,2,3 | 5,6,7,8 | 10,11,0,1.
- Stall: basic config with inst_stall high in cycles 5..7 -> no rd_vld and no ppad_wen in cycles 5..7; step sequence identical, shifted by 3 cycles; done in cycle 30.
- Abort: inst_reset in cycle 10 -> from cycle 11 all outputs 0 and state IDLE; no done. A new start in cycle 12 runs a full clean sequence.
- Zero config: pm=0, start -> done in cycle 1; rd_vld and ppad_wen never asserted.
- Start while busy: a second inst_start in cycle 5 of a run -> ignored; the sequence matches the basic test exactly.

Source files
------------

// File: rtl/pe_pad_sched.sv
// Loop-nest scheduler for one PE: walks Tw > R > Pch > Pm, issuing one MAC step
// per cycle with scratchpad read addresses, and a LAT-delayed PPad write-back.
module pe_pad_sched #(
  parameter int IPadSize = 12,
  parameter int WPadSize = 48,
  parameter int PPadSize = 64,
  parameter int IAW      = $clog2(IPadSize),
  parameter int WAW      = $clog2(WPadSize),
  parameter int PAW      = $clog2(PPadSize),
  parameter int LAT      = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inst_start,
  input  logic           inst_stall,
  input  logic           inst_reset,
  input  logic [3:0]     conf_pch,
  input  logic [4:0]     conf_pm,
  input  logic [3:0]     conf_r,
  input  logic [6:0]     conf_tw,
  input  logic [5:0]     conf_upix,
  output logic [IAW-1:0] ipad_raddr,
  output logic [WAW-1:0] wpad_raddr,
  output logic [PAW-1:0] ppad_raddr,
  output logic           rd_vld,
  output logic           fstpix,
  output logic           lstpix,
  output logic [PAW-1:0] ppad_waddr,
  output logic           ppad_wen,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [IAW:0]   ISZ  = (IAW+1)'(IPadSize);
  localparam logic [IAW-1:0] ILST = IAW'(IPadSize - 1);

  state_t state, state_n;

  logic [3:0]     pch_q, r_q;
  logic [4:0]     pm_q;
  logic [6:0]     tw_q;
  logic [IAW-1:0] upix_q;

  logic [3:0]     pch_e, r_e;
  logic [4:0]     pm_e;
  logic [6:0]     tw_e;
  logic [IAW-1:0] upix_e;

  logic [4:0]     m_cnt;
  logic [3:0]     c_cnt, r_cnt;
  logic [6:0]     t_cnt;
  logic [WAW-1:0] w_cnt;
  logic [IAW-1:0] i_addr, i_base;
  logic [PAW-1:0] p_addr, p_base;

  logic           m_wrap, c_wrap, r_wrap, t_wrap;
  logic [IAW:0]   i_base_sum;
  logic [IAW-1:0] i_base_nxt, i_addr_inc;
  logic [PAW-1:0] p_base_nxt;

  logic           rd_vld_q;
  logic [LAT-1:0] pipe_vld, pipe_low;
  logic [PAW-1:0] pipe_addr [LAT];

  logic           cfg_zero, issue, freeze, pending, clear;

  // The start cycle issues step 0 directly, so the live conf inputs stand in
  // for the latched config while still in IDLE.
  assign pch_e  = (state == IDLE) ? conf_pch  : pch_q;
  assign pm_e   = (state == IDLE) ? conf_pm   : pm_q;
  assign r_e    = (state == IDLE) ? conf_r    : r_q;
  assign tw_e   = (state == IDLE) ? conf_tw   : tw_q;
  assign upix_e = (state == IDLE) ? IAW'(32'(conf_upix) % IPadSize) : upix_q;

  assign cfg_zero = (conf_pch == 4'd0) || (conf_pm == 5'd0) ||
                    (conf_r == 4'd0) || (conf_tw == 7'd0);

  assign m_wrap = (m_cnt == pm_e - 5'd1);
  assign c_wrap = m_wrap && (c_cnt == pch_e - 4'd1);
  assign r_wrap = c_wrap && (r_cnt == r_e - 4'd1);
  assign t_wrap = r_wrap && (t_cnt == tw_e - 7'd1);

  assign i_base_sum = {1'b0, i_base} + {1'b0, upix_e};
  assign i_base_nxt = IAW'((i_base_sum >= ISZ) ? (i_base_sum - ISZ) : i_base_sum);
  assign i_addr_inc = (i_addr == ILST) ? '0 : i_addr + 1'b1;
  assign p_base_nxt = p_base + PAW'(pm_e);

  assign clear    = rst || inst_reset;
  assign freeze   = inst_stall && ((state == RUN) || (state == DRAIN));
  assign pipe_low = pipe_vld << 1;
  assign pending  = rd_vld_q || (|pipe_low);

  assign rd_vld     = rd_vld_q && !freeze;
  assign ppad_wen   = pipe_vld[LAT-1] && !freeze;
  assign ppad_waddr = pipe_addr[LAT-1];
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      IDLE: begin
        if (inst_start) begin
          if (cfg_zero) begin
            state_n = DONE;
          end else begin
            issue   = 1'b1;
            state_n = t_wrap ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (!inst_stall) begin
          issue = 1'b1;
          if (t_wrap) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!inst_stall && !pending) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      pch_q <= '0; pm_q <= '0; r_q <= '0; tw_q <= '0; upix_q <= '0;
      m_cnt <= '0; c_cnt <= '0; r_cnt <= '0; t_cnt <= '0;
      w_cnt <= '0; i_addr <= '0; i_base <= '0; p_addr <= '0; p_base <= '0;
      ipad_raddr <= '0; wpad_raddr <= '0; ppad_raddr <= '0;
      fstpix <= 1'b0; lstpix <= 1'b0; rd_vld_q <= 1'b0;
    end else begin
      if (state == IDLE && inst_start) begin
        pch_q  <= conf_pch;
        pm_q   <= conf_pm;
        r_q    <= conf_r;
        tw_q   <= conf_tw;
        upix_q <= upix_e;
      end

      if (issue) begin
        ipad_raddr <= i_addr;
        wpad_raddr <= w_cnt;
        ppad_raddr <= p_addr;
        fstpix     <= (r_cnt == 4'd0) && (c_cnt == 4'd0);
        lstpix     <= (r_cnt == r_e - 4'd1) && (c_cnt == pch_e - 4'd1);
        rd_vld_q   <= 1'b1;

        // Counters are returned to zero after the last step so IDLE always
        // starts the next run from the origin of the nest.
        if (t_wrap) begin
          m_cnt <= '0; c_cnt <= '0; r_cnt <= '0; t_cnt <= '0;
          w_cnt <= '0; i_addr <= '0; i_base <= '0; p_addr <= '0; p_base <= '0;
        end else if (r_wrap) begin
          m_cnt  <= '0;
          c_cnt  <= '0;
          r_cnt  <= '0;
          t_cnt  <= t_cnt + 7'd1;
          w_cnt  <= '0;
          i_base <= i_base_nxt;
          i_addr <= i_base_nxt;
          p_base <= p_base_nxt;
          p_addr <= p_base_nxt;
        end else begin
          w_cnt <= w_cnt + 1'b1;
          if (c_wrap) begin
            m_cnt  <= '0;
            c_cnt  <= '0;
            r_cnt  <= r_cnt + 4'd1;
            i_addr <= i_addr_inc;
            p_addr <= p_base;
          end else if (m_wrap) begin
            m_cnt  <= '0;
            c_cnt  <= c_cnt + 4'd1;
            i_addr <= i_addr_inc;
            p_addr <= p_base;
          end else begin
            m_cnt  <= m_cnt + 5'd1;
            p_addr <= p_addr + 1'b1;
          end
        end
      end else if (!freeze) begin
        rd_vld_q <= 1'b0;
      end
    end
  end

  // Write-back pipeline mirrors the datapath latency and freezes with it.
  always_ff @(posedge clk) begin
    if (clear) begin
      pipe_vld <= '0;
      for (int i = 0; i < LAT; i++) pipe_addr[i] <= '0;
    end else if (!freeze) begin
      pipe_vld     <= pipe_low | LAT'(rd_vld_q);
      pipe_addr[0] <= ppad_raddr;
      for (int i = 1; i < LAT; i++) pipe_addr[i] <= pipe_addr[i-1];
    end
  end

endmodule

// File: tb/tb_pe_pad_sched.sv
// Scoreboard bench for pe_pad_sched: a reference nest model fills expectation
// queues at start; a negedge monitor pops and compares as outputs appear.
module tb_pe_pad_sched;

  localparam int LAT  = 2;
  localparam int IPAD = 12;

  logic       clk = 1'b0;
  logic       rst, inst_start, inst_stall, inst_reset;
  logic [3:0] conf_pch, conf_r;
  logic [4:0] conf_pm;
  logic [6:0] conf_tw;
  logic [5:0] conf_upix;
  logic [3:0] ipad_raddr;
  logic [5:0] wpad_raddr, ppad_raddr, ppad_waddr;
  logic       rd_vld, fstpix, lstpix, ppad_wen, busy, done;

  always #5 clk = ~clk;

  pe_pad_sched #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .inst_start(inst_start), .inst_stall(inst_stall),
    .inst_reset(inst_reset), .conf_pch(conf_pch), .conf_pm(conf_pm),
    .conf_r(conf_r), .conf_tw(conf_tw), .conf_upix(conf_upix),
    .ipad_raddr(ipad_raddr), .wpad_raddr(wpad_raddr), .ppad_raddr(ppad_raddr),
    .rd_vld(rd_vld), .fstpix(fstpix), .lstpix(lstpix), .ppad_waddr(ppad_waddr),
    .ppad_wen(ppad_wen), .busy(busy), .done(done)
  );

  typedef struct {int cyc; int ipad; int wpad; int ppad; int fst; int lst;} rdExp_t;
  typedef struct {int cyc; int addr;} wrExp_t;

  rdExp_t rdQ[$];
  wrExp_t wrQ[$];

  int cyc = 0, base = 0, expDone = -1, busyEnd = 0;
  int checks = 0, failures = 0;
  bit active = 1'b0, doneSeen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  // Reference nest: direct arithmetic, stall shifts every event at or after it.
  task automatic genSteps(input int pch, input int pm, input int rr, input int tw,
                          input int upix, input int stallAt, input int stallLen,
                          input int cutoff);
    int k, d;
    rdExp_t e;
    wrExp_t w;
    k = 0;
    if (pch == 0 || pm == 0 || rr == 0 || tw == 0) begin
      expDone = 1;
      busyEnd = 1;
      return;
    end
    for (int t = 0; t < tw; t++)
      for (int ri = 0; ri < rr; ri++)
        for (int c = 0; c < pch; c++)
          for (int m = 0; m < pm; m++) begin
            e.cyc  = k + 1;
            if (e.cyc >= stallAt) e.cyc += stallLen;
            e.ipad = (((t * upix) % IPAD) + ri * pch + c) % IPAD;
            e.wpad = (ri * pch + c) * pm + m;
            e.ppad = t * pm + m;
            e.fst  = (ri == 0 && c == 0) ? 1 : 0;
            e.lst  = (ri == rr - 1 && c == pch - 1) ? 1 : 0;
            if (e.cyc <= cutoff) rdQ.push_back(e);
            w.cyc  = k + 1 + LAT;
            if (w.cyc >= stallAt) w.cyc += stallLen;
            w.addr = e.ppad;
            if (w.cyc <= cutoff) wrQ.push_back(w);
            k++;
          end
    d = k + LAT + 1 + stallLen;
    expDone = (d <= cutoff) ? d : -1;
    busyEnd = (d <= cutoff) ? d : cutoff;
  endtask

  // Called just after a posedge; that cycle becomes cycle 0 of the run.
  task automatic applyStimulus(input int pch, input int pm, input int rr, input int tw,
                               input int upix, input int stallAt, input int stallLen,
                               input int cutoff);
    doneSeen = 1'b0;
    genSteps(pch, pm, rr, tw, upix, stallAt, stallLen, cutoff);
    conf_pch   = 4'(pch);
    conf_pm    = 5'(pm);
    conf_r     = 4'(rr);
    conf_tw    = 7'(tw);
    conf_upix  = 6'(upix);
    inst_start = 1'b1;
    base       = cyc;
    active     = 1'b1;
    @(posedge clk) #1;
    inst_start = 1'b0;
  endtask

  task automatic gotoCycle(input int k);
    while (cyc - base < k) @(posedge clk) #1;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 300 && !doneSeen; i++) @(posedge clk) #1;
    checkOutput("done seen", int'(doneSeen), 1);
    @(posedge clk) #1;
    checkOutput("reads left", rdQ.size(), 0);
    checkOutput("writes left", wrQ.size(), 0);
    rdQ.delete();
    wrQ.delete();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " rd_vld"}, int'(rd_vld), 0);
    checkOutput({tag, " ppad_wen"}, int'(ppad_wen), 0);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " done"}, int'(done), 0);
    checkOutput({tag, " ipad"}, int'(ipad_raddr), 0);
    checkOutput({tag, " wpad"}, int'(wpad_raddr), 0);
    checkOutput({tag, " ppad"}, int'(ppad_raddr), 0);
    checkOutput({tag, " waddr"}, int'(ppad_waddr), 0);
    checkOutput({tag, " fstpix"}, int'(fstpix), 0);
    checkOutput({tag, " lstpix"}, int'(lstpix), 0);
  endtask

  int     rel;
  rdExp_t re;
  wrExp_t we;

  always @(negedge clk) begin
    if (active) begin
      rel = cyc - base;
      checkOutput("busy", int'(busy), (rel >= 1 && rel <= busyEnd) ? 1 : 0);
      if (rd_vld) begin
        if (rdQ.size() == 0) checkOutput("unexpected rd_vld at cycle", rel, -1);
        else begin
          re = rdQ.pop_front();
          checkOutput("rd cycle", rel, re.cyc);
          checkOutput("ipad_raddr", int'(ipad_raddr), re.ipad);
          checkOutput("wpad_raddr", int'(wpad_raddr), re.wpad);
          checkOutput("ppad_raddr", int'(ppad_raddr), re.ppad);
          checkOutput("fstpix", int'(fstpix), re.fst);
          checkOutput("lstpix", int'(lstpix), re.lst);
        end
      end
      if (ppad_wen) begin
        if (wrQ.size() == 0) checkOutput("unexpected ppad_wen at cycle", rel, -1);
        else begin
          we = wrQ.pop_front();
          checkOutput("wr cycle", rel, we.cyc);
          checkOutput("ppad_waddr", int'(ppad_waddr), we.addr);
        end
      end
      if (done) begin
        checkOutput("done cycle", rel, expDone);
        doneSeen = 1'b1;
      end
    end
  end

  initial begin
    rst = 1'b1; inst_start = 1'b0; inst_stall = 1'b0; inst_reset = 1'b0;
    conf_pch = '0; conf_pm = '0; conf_r = '0; conf_tw = '0; conf_upix = '0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(posedge clk) #1;

    $display("[TB] basic nest");
    applyStimulus(2, 3, 2, 2, 2, 1000, 0, 1000);
    waitDone();

    $display("[TB] ipad wrap");
    applyStimulus(1, 1, 4, 3, 5, 1000, 0, 1000);
    waitDone();

    $display("[TB] stall cycles 5..7");
    applyStimulus(2, 3, 2, 2, 2, 5, 3, 1000);
    gotoCycle(5);
    inst_stall = 1'b1;
    gotoCycle(8);
    inst_stall = 1'b0;
    waitDone();

    $display("[TB] abort at cycle 10");
    applyStimulus(2, 3, 2, 2, 2, 1000, 0, 10);
    gotoCycle(10);
    inst_reset = 1'b1;
    gotoCycle(11);
    inst_reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("abort");
    checkOutput("abort reads left", rdQ.size(), 0);
    checkOutput("abort writes left", wrQ.size(), 0);
    gotoCycle(12);
    applyStimulus(2, 3, 2, 2, 2, 1000, 0, 1000);
    waitDone();

    $display("[TB] zero config");
    applyStimulus(2, 0, 2, 2, 2, 1000, 0, 1000);
    waitDone();

    $display("[TB] start while busy");
    applyStimulus(2, 3, 2, 2, 2, 1000, 0, 1000);
    gotoCycle(5);
    conf_pch = 4'd1; conf_pm = 5'd1; conf_r = 4'd1; conf_tw = 7'd1; conf_upix = 6'd7;
    inst_start = 1'b1;
    gotoCycle(6);
    inst_start = 1'b0;
    waitDone();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
